fp_compare_pipe: RTL
====================

Name: fp_compare_pipe

Overview:
- Parametrised, pipelined successor to the combinational FP comparator.
- Executes FEQ/FLT/FLE/FMIN/FMAX/FCLASS for any IEEE-754 binary format set by EXPONENT_WIDTH/FRACTION_WIDTH.
- Has a valid/ready request/response handshake, configurable latency, per-op tag and flush.
- Sits in the FP execute stage between the FP issue queue and the FP/int writeback arbiter.

Parameters:
EXPONENT_WIDTH, 8, exponent field width (8 = single, 11 = double)
FRACTION_WIDTH, 23, fraction field width (23 = single, 52 = double)
WIDTH, 1+EXPONENT_WIDTH+FRACTION_WIDTH, operand width (derived)
LATENCY, 2, pipeline register stages from acceptance to response, legal range 1..4
TAG_WIDTH, 4, width of opaque op tag carried alongside each op

Ports:
clk  input  1  clock
rst  input  1  synchronous active-low reset (reset applied when rst == 0 at clk rising edge)
flush  input  1  kill all in-flight ops this cycle
reqValid  input  1  request valid
reqReady  output  1  request accepted when reqValid && reqReady
reqCommand  input  3  FpCompareCommand: Eq, Lt, Le, Min, Max, Class
reqTag  input  TAG_WIDTH  op tag
reqSrc1  input  WIDTH  operand 1
reqSrc2  input  WIDTH  operand 2 (ignored for Class)
respValid  output  1  response valid
respReady  input  1  consumer ready
respTag  output  TAG_WIDTH  tag of the responding op
respIntResult  output  32  FEQ/FLT/FLE result (0/1) or FCLASS 10-bit mask, zero-extended
respFpResult  output  WIDTH  FMIN/FMAX result; 0 for other commands
respFlags  output  5  fflags_t {NV,DZ,OF,UF,NX}

Behaviour:
- Reset (rst == 0): all stage valid bits are 0. respValid=0; respTag, respIntResult, respFpResult and respFlags are all 0. reqReady=0 during reset and 1 on the first cycle after reset.
- Classification:
  - Zero: exp==0 && frac==0.
  - Subnormal: exp==0 && frac!=0.
  - Inf: exp all-1 && frac==0.
  - NaN: exp all-1 && frac!=0.
  - sNaN: NaN with frac MSB==0.
- Eq/Lt/Le:
  - +0 and -0 compare equal.
  - Any NaN operand gives result 0.
  - Eq raises NV only on sNaN. Lt/Le raise NV on any NaN.
- Min/Max:
  - -0 is less than +0.
  - One NaN operand: return the other operand.
  - Both NaN: return canonical quiet NaN (sign 0, exp all-1, frac MSB 1, rest 0).
  - NV on any sNaN operand.
- Class: RISC-V FCLASS one-hot bits 0..9 (-inf, -normal, -subnormal, -0, +0, +subnormal, +normal, +inf, sNaN, qNaN). Flags 0.
- Pipeline:
  - Compute is done in stage 0 from registered inputs. Later stages only carry results.
  - Stages are bubble-collapsing: stage i loads when its valid is 0 or stage i+1 (or the output when i is last) accepts this cycle.
  - reqReady = stage 0 can load.
  - Latency: response appears exactly LATENCY cycles after acceptance when respReady stays 1.
  - Throughput: 1 op/cycle with no backpressure.
- Backpressure: while respValid && !respReady, all response fields hold stable. Ops queue in stages. reqReady drops once all LATENCY stages hold valid ops. No op is dropped, duplicated or reordered.
- Flush:
  - All stage valid bits clear at the next edge, including the presented response.
  - A request presented in the flush cycle is not accepted: reqReady=0 while flush=1.
  - Flush and rst together behave as reset.
- Reset mid-operation: in-flight ops are discarded silently. No response is ever produced for them.
- Output regs update only on a register load; data in stages with valid=0 is don't-care, but outputs are 0 when respValid=0.

Decomposition:
- Shared package FpTypes holds:
  - FpCompareCommand enum, 3-bit: Eq=0, Lt=1, Le=2, Min=3, Max=4, Class=5.
  - FCLASS bit-index constants.
  - fflags_t.
- Sub-module fp_compare_core: purely combinational single-op compare/min/max/class, parametrised on EXPONENT_WIDTH/FRACTION_WIDTH. It is instantiated once. fp_compare_pipe owns the handshake, stages and flush.

Test Plan:
- Eq(0x00000000, 0x80000000) -> respIntResult=1, flags=0. Min(0x00000000, 0x80000000) -> respFpResult=0x80000000.
- Max(0x7FC00000, 0x3F800000) -> 0x3F800000, NV=0. Min(0x7F800001, 0x40000000) -> 0x40000000, NV=1. Max(0x7FC00000, 0x7F800001) -> 0x7FC00000, NV=1.
- Lt(0x7FC00000, 0x3F800000) -> respIntResult=0, NV=1. Eq on the same operands -> 0, NV=0. Class(0xFF800000) -> 0x001. Class(0x00000001) -> 0x020.
- LATENCY=2, respReady=1, 8 back-to-back ops -> first respValid 2 cycles after first accept, then 1 response/cycle, tags 0..7 in order.
- LATENCY=2, respReady=0 for 6 cycles, reqValid held high -> reqReady=0 after 2 accepts, outputs stable. On respReady=1, responses follow in order with no loss.
- Flush with 2 ops in flight -> respValid=0 next cycle and no response for those tags. Repeat with rst=0 mid-stream -> all outputs 0 and reqReady=1 on the cycle after rst returns to 1.

Source files
------------

// File: rtl/fp_compare_pipe_pkg.sv
// Shared types for the pipelined floating-point comparator.
//   fp_compare_command_e : 3-bit op select carried on reqCommand
//   FCLASS_*             : bit positions of the RISC-V FCLASS one-hot mask
//   fflags_t             : IEEE exception flags {NV,DZ,OF,UF,NX}
package fp_compare_pipe_pkg;

  typedef enum logic [2:0] {
    CMD_EQ    = 3'd0,
    CMD_LT    = 3'd1,
    CMD_LE    = 3'd2,
    CMD_MIN   = 3'd3,
    CMD_MAX   = 3'd4,
    CMD_CLASS = 3'd5
  } fp_compare_command_e;

  localparam int FCLASS_NEG_INF       = 0;
  localparam int FCLASS_NEG_NORMAL    = 1;
  localparam int FCLASS_NEG_SUBNORMAL = 2;
  localparam int FCLASS_NEG_ZERO      = 3;
  localparam int FCLASS_POS_ZERO      = 4;
  localparam int FCLASS_POS_SUBNORMAL = 5;
  localparam int FCLASS_POS_NORMAL    = 6;
  localparam int FCLASS_POS_INF       = 7;
  localparam int FCLASS_SNAN          = 8;
  localparam int FCLASS_QNAN          = 9;
  localparam int FCLASS_WIDTH         = 10;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

endpackage

// File: rtl/fp_compare_core.sv
// Combinational single-op FP compare / min / max / classify.
//   cmd        : fp_compare_command_e encoding
//   src1, src2 : IEEE-754 operands (src2 unused for CMD_CLASS)
//   int_result : Eq/Lt/Le boolean in bit 0, or FCLASS mask in bits 9:0
//   fp_result  : Min/Max result, 0 for every other command
//   flags      : only NV can be raised by these operations
module fp_compare_core
  import fp_compare_pipe_pkg::*;
#(
  parameter int EXPONENT_WIDTH = 8,
  parameter int FRACTION_WIDTH = 23,
  localparam int WIDTH = 1 + EXPONENT_WIDTH + FRACTION_WIDTH
) (
  input  logic [2:0]       cmd,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic [31:0]      int_result,
  output logic [WIDTH-1:0] fp_result,
  output fflags_t          flags
);

  localparam logic [WIDTH-1:0] CANONICAL_QNAN =
    {1'b0, {EXPONENT_WIDTH{1'b1}}, 1'b1, {(FRACTION_WIDTH-1){1'b0}}};

  logic                      a_sign, b_sign;
  logic [EXPONENT_WIDTH-1:0] a_exp, b_exp;
  logic [FRACTION_WIDTH-1:0] a_frac, b_frac;
  logic [WIDTH-2:0]          a_mag, b_mag;

  assign {a_sign, a_exp, a_frac} = src1;
  assign {b_sign, b_exp, b_frac} = src2;
  assign a_mag = src1[WIDTH-2:0];
  assign b_mag = src2[WIDTH-2:0];

  logic a_exp_ones, a_exp_zero, a_frac_zero;
  logic b_exp_ones, b_exp_zero, b_frac_zero;
  logic a_zero, a_sub, a_norm, a_inf, a_nan, a_snan;
  logic b_zero, b_nan, b_snan;

  assign a_exp_ones  = &a_exp;
  assign a_exp_zero  = ~|a_exp;
  assign a_frac_zero = ~|a_frac;
  assign b_exp_ones  = &b_exp;
  assign b_exp_zero  = ~|b_exp;
  assign b_frac_zero = ~|b_frac;

  assign a_zero = a_exp_zero & a_frac_zero;
  assign a_sub  = a_exp_zero & ~a_frac_zero;
  assign a_norm = ~a_exp_zero & ~a_exp_ones;
  assign a_inf  = a_exp_ones & a_frac_zero;
  assign a_nan  = a_exp_ones & ~a_frac_zero;
  // A NaN is signalling when the quiet bit (fraction MSB) is clear.
  assign a_snan = a_nan & ~a_frac[FRACTION_WIDTH-1];

  assign b_zero = b_exp_zero & b_frac_zero;
  assign b_nan  = b_exp_ones & ~b_frac_zero;
  assign b_snan = b_nan & ~b_frac[FRACTION_WIDTH-1];

  logic any_nan, any_snan, both_zero;
  assign any_nan   = a_nan | b_nan;
  assign any_snan  = a_snan | b_snan;
  assign both_zero = a_zero & b_zero;

  // Sign-magnitude ordering in which -0 sorts below +0. Min/Max use it
  // directly; Lt masks out the +/-0 pair so that they compare equal.
  logic a_below_b;
  always_comb begin
    if (a_sign != b_sign) begin
      a_below_b = a_sign;
    end else if (a_sign) begin
      a_below_b = a_mag > b_mag;
    end else begin
      a_below_b = a_mag < b_mag;
    end
  end

  logic is_eq, is_lt, is_le;
  assign is_eq = ~any_nan & ((src1 == src2) | both_zero);
  assign is_lt = ~any_nan & ~both_zero & a_below_b;
  assign is_le = is_eq | is_lt;

  logic [FCLASS_WIDTH-1:0] class_mask;
  always_comb begin
    class_mask = '0;
    class_mask[FCLASS_NEG_INF]       = a_sign & a_inf;
    class_mask[FCLASS_NEG_NORMAL]    = a_sign & a_norm;
    class_mask[FCLASS_NEG_SUBNORMAL] = a_sign & a_sub;
    class_mask[FCLASS_NEG_ZERO]      = a_sign & a_zero;
    class_mask[FCLASS_POS_ZERO]      = ~a_sign & a_zero;
    class_mask[FCLASS_POS_SUBNORMAL] = ~a_sign & a_sub;
    class_mask[FCLASS_POS_NORMAL]    = ~a_sign & a_norm;
    class_mask[FCLASS_POS_INF]       = ~a_sign & a_inf;
    class_mask[FCLASS_SNAN]          = a_snan;
    class_mask[FCLASS_QNAN]          = a_nan & ~a_snan;
  end

  // Min/Max share the NaN handling; only the final ordered pick differs.
  logic [WIDTH-1:0] min_result, max_result;
  always_comb begin
    if (a_nan & b_nan) begin
      min_result = CANONICAL_QNAN;
      max_result = CANONICAL_QNAN;
    end else if (a_nan) begin
      min_result = src2;
      max_result = src2;
    end else if (b_nan) begin
      min_result = src1;
      max_result = src1;
    end else begin
      min_result = a_below_b ? src1 : src2;
      max_result = a_below_b ? src2 : src1;
    end
  end

  always_comb begin
    int_result = '0;
    fp_result  = '0;
    flags      = '0;
    case (fp_compare_command_e'(cmd))
      CMD_EQ: begin
        int_result[0] = is_eq;
        flags.nv      = any_snan;   // quiet comparison
      end
      CMD_LT: begin
        int_result[0] = is_lt;
        flags.nv      = any_nan;    // signalling comparison
      end
      CMD_LE: begin
        int_result[0] = is_le;
        flags.nv      = any_nan;
      end
      CMD_MIN: begin
        fp_result = min_result;
        flags.nv  = any_snan;
      end
      CMD_MAX: begin
        fp_result = max_result;
        flags.nv  = any_snan;
      end
      CMD_CLASS: begin
        int_result[FCLASS_WIDTH-1:0] = class_mask;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fp_compare_pipe.sv
// Pipelined FP comparator with valid/ready handshake, tag and flush.
//   clk, rst         : clock, synchronous active-low reset
//   flush            : discard every in-flight op at the next edge
//   reqValid/Ready   : request handshake (reqCommand, reqTag, reqSrc1/2)
//   respValid/Ready  : response handshake (respTag, respIntResult,
//                      respFpResult, respFlags); all zero when idle
// The op is evaluated by fp_compare_core on acceptance and its result
// enters stage 0; stages 1..LATENCY-1 only move results. The last stage
// drives the response, so an op shows up LATENCY cycles after acceptance.
module fp_compare_pipe
  import fp_compare_pipe_pkg::*;
#(
  parameter int EXPONENT_WIDTH = 8,
  parameter int FRACTION_WIDTH = 23,
  parameter int LATENCY        = 2,
  parameter int TAG_WIDTH      = 4,
  localparam int WIDTH = 1 + EXPONENT_WIDTH + FRACTION_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 reqValid,
  output logic                 reqReady,
  input  logic [2:0]           reqCommand,
  input  logic [TAG_WIDTH-1:0] reqTag,
  input  logic [WIDTH-1:0]     reqSrc1,
  input  logic [WIDTH-1:0]     reqSrc2,
  output logic                 respValid,
  input  logic                 respReady,
  output logic [TAG_WIDTH-1:0] respTag,
  output logic [31:0]          respIntResult,
  output logic [WIDTH-1:0]     respFpResult,
  output fflags_t              respFlags
);

  typedef struct packed {
    logic [TAG_WIDTH-1:0] tag;
    logic [31:0]          int_result;
    logic [WIDTH-1:0]     fp_result;
    fflags_t              flags;
  } stage_t;

  // ---------------------------------------------------------------------
  // Compute on the incoming request
  // ---------------------------------------------------------------------
  logic [31:0]      core_int_result;
  logic [WIDTH-1:0] core_fp_result;
  fflags_t          core_flags;
  stage_t           core_data;

  fp_compare_core #(
    .EXPONENT_WIDTH(EXPONENT_WIDTH),
    .FRACTION_WIDTH(FRACTION_WIDTH)
  ) u_core (
    .cmd       (reqCommand),
    .src1      (reqSrc1),
    .src2      (reqSrc2),
    .int_result(core_int_result),
    .fp_result (core_fp_result),
    .flags     (core_flags)
  );

  assign core_data = '{tag:        reqTag,
                       int_result: core_int_result,
                       fp_result:  core_fp_result,
                       flags:      core_flags};

  // ---------------------------------------------------------------------
  // Bubble-collapsing handshake
  // ---------------------------------------------------------------------
  logic   stage_valid_q [LATENCY];
  stage_t stage_data_q  [LATENCY];
  logic [LATENCY-1:0] valid_vec;

  // load[i]: stage i may take new contents this cycle.
  // load[LATENCY] stands for the consumer, so the last stage needs no
  // special case. adv[i]: stage i hands its op downstream this cycle.
  logic [LATENCY:0]   load;
  logic [LATENCY-1:0] adv;

  always_comb begin
    load          = '0;
    adv           = '0;
    load[LATENCY] = respReady;
    for (int i = LATENCY - 1; i >= 0; i--) begin
      adv[i]  = valid_vec[i] & load[i+1];
      load[i] = ~valid_vec[i] | adv[i];
    end
  end

  logic req_accept;
  assign reqReady   = rst & ~flush & load[0];
  assign req_accept = reqValid & reqReady;

  // ---------------------------------------------------------------------
  // Stage registers
  // ---------------------------------------------------------------------
  for (genvar gi = 0; gi < LATENCY; gi++) begin : g_stage
    logic   in_valid;
    stage_t in_data;
    logic   stage_valid_d;
    stage_t stage_data_d;

    if (gi == 0) begin : g_head
      assign in_valid = req_accept;
      assign in_data  = core_data;
    end else begin : g_body
      assign in_valid = adv[gi-1];
      assign in_data  = stage_data_q[gi-1];
    end

    assign valid_vec[gi] = stage_valid_q[gi];

    always_comb begin
      stage_valid_d = stage_valid_q[gi];
      stage_data_d  = stage_data_q[gi];
      if (load[gi]) begin
        stage_valid_d = in_valid;
        // Payload only moves with a real op so a held response never
        // changes underneath a stalled consumer.
        if (in_valid) begin
          stage_data_d = in_data;
        end
      end
      if (flush) begin
        stage_valid_d = 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        stage_valid_q[gi] <= 1'b0;
      end else begin
        stage_valid_q[gi] <= stage_valid_d;
      end
      // Payload is don't-care while invalid, so it is not reset.
      stage_data_q[gi] <= stage_data_d;
    end
  end

  // ---------------------------------------------------------------------
  // Response: masked so that idle outputs read as zero
  // ---------------------------------------------------------------------
  stage_t last_data;
  assign last_data     = stage_data_q[LATENCY-1];
  assign respValid     = valid_vec[LATENCY-1];
  assign respTag       = respValid ? last_data.tag        : '0;
  assign respIntResult = respValid ? last_data.int_result : '0;
  assign respFpResult  = respValid ? last_data.fp_result  : '0;
  assign respFlags     = respValid ? last_data.flags      : '0;

endmodule
